pll_rst_seq: RTL and testbench
==============================

PLL_RST_SEQ -- requirements
Module: pll_rst_seq

Interface
REQ-001 SHALL have parameter RST_PULSE_CYC, default 1250: cycles pll_rst_o is held high per attempt (10 us at 125 MHz).
REQ-002 SHALL have parameter LOCK_STABLE_CYC, default 12500: consecutive synchronized-lock cycles required before release.
REQ-003 SHALL have parameter LOCK_TIMEOUT_CYC, default 125000: cycles allowed to wait for lock per attempt.
REQ-004 SHALL have parameter MAX_RETRY, default 7: timed-out attempts allowed before FAIL; range 1..7.
REQ-005 SHALL have port clk, input, 1: free-running 125 MHz reference clock, the same clock that feeds the PLL clkin1; never the PLL output.
REQ-006 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-007 SHALL have port pll_lock_i, input, 1: PLL lock flag, asynchronous to clk.
REQ-008 SHALL have port relock_req_i, input, 1: single-cycle request to restart the sequence.
REQ-009 SHALL have port pll_rst_o, output, 1: active-high PLL reset, connects to pll_rst.
REQ-010 SHALL have port sys_rst_n_o, output, 1: active-low reset for logic clocked by the PLL outputs.
REQ-011 SHALL have port locked_o, output, 1: high only in RUN.
REQ-012 SHALL have port fail_o, output, 1: high only in FAIL.
REQ-013 SHALL have port retry_cnt_o, output, 3: timed-out attempts since the last RUN entry or restart.

Function
REQ-014 SHALL synchronize pll_lock_i through two flops (lock_s); all decisions use lock_s, so lock_s lags pll_lock_i by 2 cycles.
REQ-015 SHALL register all outputs; each output changes in the cycle after the state transition that causes it.
REQ-016 SHALL implement states RST_PLL, WAIT_LOCK, STABLE, RUN and FAIL, with one shared cycle counter cleared on every state entry.
REQ-017 RST_PLL: pll_rst_o=1; after RST_PULSE_CYC cycles, go to WAIT_LOCK.
REQ-018 WAIT_LOCK: pll_rst_o=0.
- lock_s=1: go to STABLE.
- Counter reaches LOCK_TIMEOUT_CYC-1 with lock_s=0: increment retry_cnt_o.
- If the incremented count equals MAX_RETRY, go to FAIL; otherwise go to RST_PLL.
REQ-019 STABLE: lock_s=0 returns to WAIT_LOCK with the timeout restarted and retry_cnt_o unchanged; LOCK_STABLE_CYC consecutive lock_s=1 cycles go to RUN.
REQ-020 RUN: sys_rst_n_o=1, locked_o=1, retry_cnt_o cleared on entry; lock_s=0 goes to RST_PLL, so sys_rst_n_o is low 1 cycle after lock_s falls.
REQ-021 FAIL: pll_rst_o=1, sys_rst_n_o=0, fail_o=1, held until relock_req_i or rst_n.
REQ-022 sys_rst_n_o SHALL be 0 in every state except RUN.
REQ-023 relock_req_i=1 in any state SHALL force RST_PLL and clear retry_cnt_o.
- This has priority over every other transition in the same cycle.
- A request during RST_PLL restarts the pulse count.
REQ-024 Counters SHALL be sized $clog2 of the largest parameter plus 1 and SHALL never wrap.
REQ-025 retry_cnt_o SHALL never exceed MAX_RETRY.

Reset
REQ-026 While rst_n=0, the block SHALL hold:
- state=RST_PLL, counter=0;
- pll_rst_o=1, sys_rst_n_o=0, locked_o=0, fail_o=0, retry_cnt_o=0;
- synchronizer flops=0.
REQ-027 On rst_n deassertion, the RST_PLL pulse SHALL start counting at the first clk edge.
REQ-028 Assertion of rst_n mid-sequence SHALL abort immediately, with no partial-output glitch.

Configuration
REQ-029 When macro PLL_RST_SEQ_LOSS_CNT_EN is defined, the block SHALL add output lock_loss_cnt_o, 8 bits:
- reset value 0;
- increments on each RUN->RST_PLL transition caused by lock_s=0;
- saturates at 255;
- cleared only by rst_n.
REQ-030 Without PLL_RST_SEQ_LOSS_CNT_EN, the port and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification (RST_PULSE_CYC=4, LOCK_STABLE_CYC=8, LOCK_TIMEOUT_CYC=20, MAX_RETRY=2)
REQ-031 Normal lock: rst_n release with pll_lock_i rising at cycle 10 -> pll_rst_o high for cycles 1-4, then sys_rst_n_o=1 and locked_o=1 at cycle 10+2+8+1, retry_cnt_o=0.
REQ-032 Lock never asserts -> two timed-out attempts with two pll_rst_o pulses of 4 cycles, then fail_o=1, pll_rst_o=1 and retry_cnt_o=2 held.
REQ-033 Lock glitch in STABLE: lock high for 5 cycles, low for 1, high again -> locked_o rises only after 8 further consecutive high cycles.
REQ-034 Loss in RUN -> sys_rst_n_o=0 and locked_o=0 three cycles after pll_lock_i falls, then a new 4-cycle pll_rst_o pulse; with the macro, lock_loss_cnt_o increments by 1.
REQ-035 relock_req_i in FAIL -> fail_o=0 and retry_cnt_o=0 next cycle, and a fresh RST_PLL pulse.
REQ-036 relock_req_i coincident with a timeout in WAIT_LOCK -> RST_PLL entered with retry_cnt_o=0, not incremented.

Source files
------------

// File: rtl/pll_rst_seq.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable lock, then releases the
// PLL-domain reset. Optional lock-loss counter port is enabled by PLL_RST_SEQ_LOSS_CNT_EN.
module pll_rst_seq #(
    parameter int RST_PULSE_CYC    = 1250,
    parameter int LOCK_STABLE_CYC  = 12500,
    parameter int LOCK_TIMEOUT_CYC = 125000,
    parameter int MAX_RETRY        = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_lock_i,
    input  logic       relock_req_i,
    output logic       pll_rst_o,
    output logic       sys_rst_n_o,
    output logic       locked_o,
    output logic       fail_o,
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
    output logic [7:0] lock_loss_cnt_o,
`endif
    output logic [2:0] retry_cnt_o
);

    localparam int MAX_AB = (RST_PULSE_CYC > LOCK_STABLE_CYC) ? RST_PULSE_CYC : LOCK_STABLE_CYC;
    localparam int MAX_P  = (MAX_AB > LOCK_TIMEOUT_CYC) ? MAX_AB : LOCK_TIMEOUT_CYC;
    localparam int CW     = $clog2(MAX_P) + 1;

    typedef enum logic [2:0] {S_RST, S_WAIT, S_STABLE, S_RUN, S_FAIL} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_sync1;
    logic            r_lock_s;

    state_t          w_nxt_state;
    logic [CW-1:0]   w_nxt_cnt;
    logic [2:0]      w_nxt_retry;
    logic [2:0]      w_retry_inc;
    logic            w_loss_inc;

    assign w_retry_inc = retry_cnt_o + 3'd1;

    // Every state exit lands on a counter limit, so the counter never wraps.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt + 1'b1;
        w_nxt_retry = retry_cnt_o;
        w_loss_inc  = 1'b0;
        if (relock_req_i) begin
            w_nxt_state = S_RST;
            w_nxt_cnt   = '0;
            w_nxt_retry = 3'd0;
        end else begin
            case (r_state)
                S_RST: begin
                    if (r_cnt == CW'(RST_PULSE_CYC - 1)) begin
                        w_nxt_state = S_WAIT;
                        w_nxt_cnt   = '0;
                    end
                end
                S_WAIT: begin
                    if (r_lock_s) begin
                        w_nxt_state = S_STABLE;
                        w_nxt_cnt   = '0;
                    end else if (r_cnt == CW'(LOCK_TIMEOUT_CYC - 1)) begin
                        w_nxt_retry = w_retry_inc;
                        w_nxt_state = (w_retry_inc == 3'(MAX_RETRY)) ? S_FAIL : S_RST;
                        w_nxt_cnt   = '0;
                    end
                end
                S_STABLE: begin
                    if (!r_lock_s) begin
                        w_nxt_state = S_WAIT;
                        w_nxt_cnt   = '0;
                    end else if (r_cnt == CW'(LOCK_STABLE_CYC - 1)) begin
                        w_nxt_state = S_RUN;
                        w_nxt_cnt   = '0;
                        w_nxt_retry = 3'd0;
                    end
                end
                S_RUN: begin
                    w_nxt_cnt = '0;
                    if (!r_lock_s) begin
                        w_nxt_state = S_RST;
                        w_loss_inc  = 1'b1;
                    end
                end
                default: w_nxt_cnt = '0;
            endcase
        end
    end

    // Outputs decode the next state so they settle on the same edge as the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1     <= 1'b0;
            r_lock_s    <= 1'b0;
            r_state     <= S_RST;
            r_cnt       <= '0;
            retry_cnt_o <= 3'd0;
            pll_rst_o   <= 1'b1;
            sys_rst_n_o <= 1'b0;
            locked_o    <= 1'b0;
            fail_o      <= 1'b0;
        end else begin
            r_sync1     <= pll_lock_i;
            r_lock_s    <= r_sync1;
            r_state     <= w_nxt_state;
            r_cnt       <= w_nxt_cnt;
            retry_cnt_o <= w_nxt_retry;
            pll_rst_o   <= (w_nxt_state == S_RST) || (w_nxt_state == S_FAIL);
            sys_rst_n_o <= (w_nxt_state == S_RUN);
            locked_o    <= (w_nxt_state == S_RUN);
            fail_o      <= (w_nxt_state == S_FAIL);
        end
    end

`ifdef PLL_RST_SEQ_LOSS_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_loss_cnt_o <= 8'd0;
        end else if (w_loss_inc && (lock_loss_cnt_o != 8'hFF)) begin
            lock_loss_cnt_o <= lock_loss_cnt_o + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pll_rst_seq.sv
// Bench for pll_rst_seq: directed cycle tables for the sequencing corner cases, then
// randomized lock/relock traffic compared every cycle against a phase-level model.
module tb_pll_rst_seq;

    localparam int RP = 4;
    localparam int ST = 8;
    localparam int TO = 20;
    localparam int MR = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       lock_in = 1'b0;
    logic       rq_in = 1'b0;
    logic       pll_rst_o, sys_rst_n_o, locked_o, fail_o;
    logic [2:0] retry_cnt_o;
    logic [6:0] dut_o;
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
    logic [7:0] lock_loss_cnt_o;
`endif

    pll_rst_seq #(
        .RST_PULSE_CYC(RP), .LOCK_STABLE_CYC(ST), .LOCK_TIMEOUT_CYC(TO), .MAX_RETRY(MR)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .pll_lock_i(lock_in),
        .relock_req_i(rq_in),
        .pll_rst_o(pll_rst_o),
        .sys_rst_n_o(sys_rst_n_o),
        .locked_o(locked_o),
        .fail_o(fail_o),
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
        .lock_loss_cnt_o(lock_loss_cnt_o),
`endif
        .retry_cnt_o(retry_cnt_o)
    );

    always #5 clk = ~clk;
    assign dut_o = {pll_rst_o, sys_rst_n_o, locked_o, fail_o, retry_cnt_o};

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: phase of the sequence, cycles spent in it, timed-out attempts.
    localparam int P_RST = 0, P_WAIT = 1, P_STB = 2, P_RUN = 3, P_FAIL = 4;
    int ph, el, m_retry, m_loss;
    bit lag_q[$];

    function automatic logic [6:0] model_out();
        return {(ph == P_RST) || (ph == P_FAIL), ph == P_RUN, ph == P_RUN, ph == P_FAIL, 3'(m_retry)};
    endfunction

    task automatic model_reset();
        ph = P_RST; el = 0; m_retry = 0; m_loss = 0;
        lag_q.delete();
        lag_q.push_back(1'b0);
        lag_q.push_back(1'b0);
    endtask

    task automatic model_edge();
        bit ls;
        ls = lag_q.pop_front();
        lag_q.push_back(lock_in);
        if (rq_in) begin
            ph = P_RST; el = 0; m_retry = 0;
        end else begin
            case (ph)
                P_RST: begin
                    el++;
                    if (el == RP) begin ph = P_WAIT; el = 0; end
                end
                P_WAIT: begin
                    if (ls) begin
                        ph = P_STB; el = 0;
                    end else begin
                        el++;
                        if (el == TO) begin
                            m_retry++;
                            el = 0;
                            ph = (m_retry == MR) ? P_FAIL : P_RST;
                        end
                    end
                end
                P_STB: begin
                    if (!ls) begin
                        ph = P_WAIT; el = 0;
                    end else begin
                        el++;
                        if (el == ST) begin ph = P_RUN; el = 0; m_retry = 0; end
                    end
                end
                P_RUN: begin
                    if (!ls) begin
                        ph = P_RST; el = 0;
                        if (m_loss < 255) m_loss++;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic chk(input string name, input logic [6:0] got, input logic [6:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got {prst,srstn,lock,fail,retry}=%b required %b", name, got, exp);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    // Reset is released 1 time unit after an edge, so the next edge closes cycle 1.
    task automatic do_reset();
        rst_n = 1'b0; lock_in = 1'b0; rq_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        int         scen;
        int         cyc;
        logic [6:0] exp;
    } tv_t;

    typedef struct {
        int lock_on;
        int lock_off;
        int lock_on2;
        int rq_at;
    } scen_t;

    function automatic logic [6:0] mk(bit p, bit s, bit l, bit f, int rc);
        return {p, s, l, f, 3'(rc)};
    endfunction

    tv_t   tv[$];
    scen_t sc[6];

    initial begin
        int seg_left;

        // Scenario stimulus: lock high in [on,off) and from on2; relock pulse at rq_at.
        sc[0] = '{10, 30, 1000, -1};   // normal lock then loss in RUN
        sc[1] = '{1000, 1000, 1000, -1}; // never locks -> FAIL
        sc[2] = '{10, 15, 16, -1};     // one-cycle glitch during STABLE
        sc[3] = '{1000, 1000, 1000, 55}; // relock out of FAIL
        sc[4] = '{1000, 1000, 1000, 24}; // relock on the timeout cycle
        sc[5] = '{1000, 1000, 1000, 3};  // relock during the reset pulse

        tv.push_back('{0, 1,  mk(1,0,0,0,0)});
        tv.push_back('{0, 4,  mk(1,0,0,0,0)});
        tv.push_back('{0, 5,  mk(0,0,0,0,0)});
        tv.push_back('{0, 20, mk(0,0,0,0,0)});
        tv.push_back('{0, 21, mk(0,1,1,0,0)});
        tv.push_back('{0, 32, mk(0,1,1,0,0)});
        tv.push_back('{0, 33, mk(1,0,0,0,0)});
        tv.push_back('{0, 36, mk(1,0,0,0,0)});
        tv.push_back('{0, 37, mk(0,0,0,0,0)});
        tv.push_back('{1, 24, mk(0,0,0,0,0)});
        tv.push_back('{1, 25, mk(1,0,0,0,1)});
        tv.push_back('{1, 28, mk(1,0,0,0,1)});
        tv.push_back('{1, 29, mk(0,0,0,0,1)});
        tv.push_back('{1, 48, mk(0,0,0,0,1)});
        tv.push_back('{1, 49, mk(1,0,0,1,2)});
        tv.push_back('{1, 70, mk(1,0,0,1,2)});
        tv.push_back('{2, 26, mk(0,0,0,0,0)});
        tv.push_back('{2, 27, mk(0,1,1,0,0)});
        tv.push_back('{3, 55, mk(1,0,0,1,2)});
        tv.push_back('{3, 56, mk(1,0,0,0,0)});
        tv.push_back('{3, 59, mk(1,0,0,0,0)});
        tv.push_back('{3, 60, mk(0,0,0,0,0)});
        tv.push_back('{4, 24, mk(0,0,0,0,0)});
        tv.push_back('{4, 25, mk(1,0,0,0,0)});
        tv.push_back('{4, 49, mk(1,0,0,0,1)});
        tv.push_back('{4, 53, mk(0,0,0,0,1)});
        tv.push_back('{5, 3,  mk(1,0,0,0,0)});
        tv.push_back('{5, 4,  mk(1,0,0,0,0)});
        tv.push_back('{5, 7,  mk(1,0,0,0,0)});
        tv.push_back('{5, 8,  mk(0,0,0,0,0)});

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", dut_o, 7'b1000000);
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
        chk8("reset_loss_cnt", lock_loss_cnt_o, 8'd0);
`endif

        for (int s = 0; s < 6; s++) begin
            do_reset();
            for (int c = 1; c <= 70; c++) begin
                lock_in = ((c >= sc[s].lock_on) && (c < sc[s].lock_off)) || (c >= sc[s].lock_on2);
                rq_in   = (c == sc[s].rq_at);
                foreach (tv[i]) begin
                    if (tv[i].scen == s && tv[i].cyc == c)
                        chk($sformatf("scen%0d_cyc%0d", s, c), dut_o, tv[i].exp);
                end
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
                if (s == 0 && c == 32) chk8("loss_cnt_before", lock_loss_cnt_o, 8'd0);
                if (s == 0 && c == 33) chk8("loss_cnt_after", lock_loss_cnt_o, 8'd1);
`endif
                tick();
            end
        end

        // Asynchronous reset in RUN must drop the outputs without waiting for an edge.
        do_reset();
        lock_in = 1'b1;
        repeat (20) tick();
        chk("pre_abort_run", dut_o, 7'b0110000);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_abort", dut_o, 7'b1000000);

        // Randomized lock traffic against the model, compared every cycle.
        do_reset();
        seg_left = 0;
        for (int c = 1; c <= 4000; c++) begin
            if (seg_left == 0) begin
                lock_in  = ($urandom_range(0, 3) != 0);
                seg_left = lock_in ? $urandom_range(1, 60) : $urandom_range(1, 50);
            end
            seg_left--;
            rq_in = ($urandom_range(0, 99) == 0);
            chk($sformatf("rand_cyc%0d", c), dut_o, model_out());
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
            chk8($sformatf("rand_loss_cyc%0d", c), lock_loss_cnt_o, 8'(m_loss));
`endif
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
